// File: rtl/rv16_alu_pkg.sv
// Shared definitions for the rv16 multi-cycle ALU: operation encodings and FSM state type.
package rv16_alu_pkg;

   localparam logic [4:0] OP_ADD    = 5'b00000;
   localparam logic [4:0] OP_SUB    = 5'b01000;
   localparam logic [4:0] OP_SLL    = 5'b00001;
   localparam logic [4:0] OP_SLT    = 5'b00010;
   localparam logic [4:0] OP_SLTU   = 5'b00011;
   localparam logic [4:0] OP_XOR    = 5'b00100;
   localparam logic [4:0] OP_SRL    = 5'b00101;
   localparam logic [4:0] OP_SRA    = 5'b01101;
   localparam logic [4:0] OP_OR     = 5'b00110;
   localparam logic [4:0] OP_AND    = 5'b00111;
   localparam logic [4:0] OP_MUL    = 5'b10000;
   localparam logic [4:0] OP_MULH   = 5'b10001;
   localparam logic [4:0] OP_MULHSU = 5'b10010;
   localparam logic [4:0] OP_MULHU  = 5'b10011;
   localparam logic [4:0] OP_DIV    = 5'b10100;
   localparam logic [4:0] OP_DIVU   = 5'b10101;
   localparam logic [4:0] OP_REM    = 5'b10110;
   localparam logic [4:0] OP_REMU   = 5'b10111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } alu_state_t;

endpackage

// File: rtl/rv16_alu_mc_if.sv
// Request/result handshake bundle between a requester and the rv16 multi-cycle ALU.
interface rv16_alu_mc_if #(parameter int XLEN = 32);
   logic            i_valid;
   logic            o_ready;
   logic [4:0]      i_alu_op;
   logic [XLEN-1:0] i_operand_a;
   logic [XLEN-1:0] i_operand_b;
   logic            i_kill;
   logic            o_valid;
   logic            i_ready;
   logic [XLEN-1:0] o_result;
   logic            o_zero;
   logic            o_overflow;
   logic            o_carry;
   logic            o_busy;

   modport master (
      output i_valid, i_alu_op, i_operand_a, i_operand_b, i_kill, i_ready,
      input  o_ready, o_valid, o_result, o_zero, o_overflow, o_carry, o_busy
   );

   modport slave (
      input  i_valid, i_alu_op, i_operand_a, i_operand_b, i_kill, i_ready,
      output o_ready, o_valid, o_result, o_zero, o_overflow, o_carry, o_busy
   );
endinterface

// File: rtl/rv16_mdu_iter.sv
// Iterative multiply (shift-add) / divide (restoring) engine, one bit per cycle on magnitudes.
module rv16_mdu_iter #(
   parameter int XLEN = 32
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            start,
   input  logic            abort,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] operand_a,
   input  logic [XLEN-1:0] operand_b,
   output logic            done,
   output logic [XLEN-1:0] result
);
   localparam int CW = $clog2(XLEN + 1);

   logic [XLEN-1:0]   hi, lo, mcand;
   logic [XLEN-1:0]   hi_n, lo_n;
   logic [2:0]        op_r;
   logic              neg_q, neg_r;
   logic [CW-1:0]     cnt;
   logic              a_neg, b_neg;
   logic [XLEN-1:0]   a_mag, b_mag;
   logic [XLEN:0]     mul_sum, r_sh, diff;
   logic [2*XLEN-1:0] prod;

   // MULH/MULHSU/DIV/REM treat a as signed; only MULH/DIV/REM treat b as signed
   assign a_neg = operand_a[XLEN-1] & (op == 3'b001 || op == 3'b010 || op == 3'b100 || op == 3'b110);
   assign b_neg = operand_b[XLEN-1] & (op == 3'b001 || op == 3'b100 || op == 3'b110);
   assign a_mag = a_neg ? -operand_a : operand_a;
   assign b_mag = b_neg ? -operand_b : operand_b;

   assign done = (cnt == CW'(1));

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         hi    <= '0;
         lo    <= '0;
         mcand <= '0;
         op_r  <= '0;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
         cnt   <= '0;
      end else if (abort) begin
         cnt <= '0;
      end else if (start) begin
         hi    <= '0;
         lo    <= a_mag;
         mcand <= b_mag;
         op_r  <= op;
         neg_q <= a_neg ^ b_neg;
         neg_r <= a_neg;
         cnt   <= CW'(XLEN);
      end else if (cnt != '0) begin
         hi  <= hi_n;
         lo  <= lo_n;
         cnt <= cnt - CW'(1);
      end
   end

   always_comb begin
      mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
      r_sh    = {hi, lo[XLEN-1]};
      diff    = r_sh - {1'b0, mcand};
      hi_n    = hi;
      lo_n    = lo;
      if (!op_r[2]) begin
         hi_n = mul_sum[XLEN:1];
         lo_n = {mul_sum[0], lo[XLEN-1:1]};
      end else if (!diff[XLEN]) begin
         hi_n = diff[XLEN-1:0];
         lo_n = {lo[XLEN-2:0], 1'b1};
      end else begin
         hi_n = r_sh[XLEN-1:0];
         lo_n = {lo[XLEN-2:0], 1'b0};
      end
   end

   // Sign correction is folded into the result of the final iteration
   always_comb begin
      prod   = neg_q ? -{hi_n, lo_n} : {hi_n, lo_n};
      result = '0;
      case (op_r)
         3'b000:                 result = prod[XLEN-1:0];
         3'b001, 3'b010, 3'b011: result = prod[2*XLEN-1:XLEN];
         3'b100, 3'b101:         result = neg_q ? -lo_n : lo_n;
         default:                result = neg_r ? -hi_n : hi_n;
      endcase
   end

endmodule

// File: rtl/rv16_alu_mc.sv
// Multi-cycle ALU: single-cycle basic ops and M-extension fast paths, iterative mul/div via rv16_mdu_iter.
//   state   | meaning
//   ST_IDLE | waiting for a request
//   ST_BUSY | iterative multiply/divide in progress
//   ST_DONE | result valid, waiting for consumer
module rv16_alu_mc #(
   parameter int XLEN = 32
) (
   input  logic               i_clk,
   input  logic               i_rst,
   rv16_alu_mc_if.slave       bus
);
   import rv16_alu_pkg::*;

   localparam int SHW = $clog2(XLEN);
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   alu_state_t      state_q, state_d;
   logic [4:0]      op;
   logic [XLEN-1:0] a, b;
   logic [SHW-1:0]  shamt;
   logic [XLEN:0]   add_w, sub_w;
   logic            accept, is_mop, b_zero, fast, is_iter;
   logic [XLEN-1:0] basic_res, mdu_res, res_q;
   logic            basic_c, basic_v, mdu_done;
   logic            zero_q, ovf_q, carry_q;

   assign op     = bus.i_alu_op;
   assign a      = bus.i_operand_a;
   assign b      = bus.i_operand_b;
   assign shamt  = b[SHW-1:0];
   assign add_w  = {1'b0, a} + {1'b0, b};
   assign sub_w  = {1'b0, a} - {1'b0, b};

   assign bus.o_ready    = (state_q == ST_IDLE) || (state_q == ST_DONE && bus.i_ready);
   assign bus.o_valid    = (state_q == ST_DONE);
   assign bus.o_busy     = (state_q == ST_BUSY);
   assign bus.o_result   = res_q;
   assign bus.o_zero     = zero_q;
   assign bus.o_overflow = ovf_q;
   assign bus.o_carry    = carry_q;

   assign accept  = bus.i_valid && bus.o_ready && !bus.i_kill;
   assign is_mop  = op[4] && !op[3];
   assign b_zero  = (b == '0);
   // Divide by zero and signed MIN/-1 resolve immediately
   assign fast    = is_mop && op[2] && (b_zero || (!op[0] && a == MIN_NEG && b == '1));
   assign is_iter = is_mop && !fast;

   always_comb begin
      basic_res = '0;
      basic_c   = 1'b0;
      basic_v   = 1'b0;
      case (op)
         OP_ADD: begin
            basic_res = add_w[XLEN-1:0];
            basic_c   = add_w[XLEN];
            basic_v   = (a[XLEN-1] == b[XLEN-1]) && (add_w[XLEN-1] != a[XLEN-1]);
         end
         OP_SUB: begin
            basic_res = sub_w[XLEN-1:0];
            basic_c   = sub_w[XLEN];
            basic_v   = (a[XLEN-1] != b[XLEN-1]) && (sub_w[XLEN-1] != a[XLEN-1]);
         end
         OP_SLL:  basic_res = a << shamt;
         OP_SLT:  basic_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
         OP_SLTU: basic_res = {{(XLEN-1){1'b0}}, a < b};
         OP_XOR:  basic_res = a ^ b;
         OP_SRL:  basic_res = a >> shamt;
         OP_SRA:  basic_res = $signed(a) >>> shamt;
         OP_OR:   basic_res = a | b;
         OP_AND:  basic_res = a & b;
         OP_DIV, OP_DIVU: basic_res = b_zero ? '1 : MIN_NEG;
         OP_REM, OP_REMU: basic_res = b_zero ? a : '0;
         default: basic_res = '0;
      endcase
   end

   rv16_mdu_iter #(.XLEN(XLEN)) u_mdu (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .start     (accept && is_iter),
      .abort     (bus.i_kill),
      .op        (op[2:0]),
      .operand_a (a),
      .operand_b (b),
      .done      (mdu_done),
      .result    (mdu_res)
   );

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (accept) state_d = is_iter ? ST_BUSY : ST_DONE;
         ST_BUSY: if (mdu_done) state_d = ST_DONE;
         ST_DONE: if (bus.i_ready) state_d = accept ? (is_iter ? ST_BUSY : ST_DONE) : ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      if (bus.i_kill) state_d = ST_IDLE;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
         res_q   <= '0;
         zero_q  <= 1'b1;
         ovf_q   <= 1'b0;
         carry_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept && !is_iter) begin
            res_q   <= basic_res;
            zero_q  <= (basic_res == '0);
            ovf_q   <= basic_v;
            carry_q <= basic_c;
         end else if (state_q == ST_BUSY && mdu_done && !bus.i_kill) begin
            res_q   <= mdu_res;
            zero_q  <= (mdu_res == '0);
            ovf_q   <= 1'b0;
            carry_q <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_rv16_alu_mc.sv
// Directed self-checking bench for rv16_alu_mc at XLEN=32.
module tb_rv16_alu_mc;
   import rv16_alu_pkg::*;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;
   int   busy_cnt;

   rv16_alu_mc_if #(.XLEN(32)) bus ();

   rv16_alu_mc #(.XLEN(32)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      bus.i_valid     = 1'b1;
      bus.i_alu_op    = op;
      bus.i_operand_a = a;
      bus.i_operand_b = b;
      @(posedge clk);
      #1;
      bus.i_valid = 1'b0;
   endtask

   // Issues one op and waits for o_valid; latency counts the accept edge as cycle 1
   task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res,
                         input logic exp_c, input logic exp_v, input int exp_lat);
      int lat;
      issue(op, a, b);
      lat      = 1;
      busy_cnt = 0;
      while (!bus.o_valid && lat < 200) begin
         if (bus.o_busy) busy_cnt++;
         @(posedge clk);
         #1;
         lat++;
      end
      check_eq({tag, "_lat"}, 64'(lat), 64'(exp_lat));
      check_eq({tag, "_res"}, 64'(bus.o_result), 64'(exp_res));
      check_eq({tag, "_zero"}, 64'(bus.o_zero), 64'(exp_res == 32'h0));
      check_eq({tag, "_carry"}, 64'(bus.o_carry), 64'(exp_c));
      check_eq({tag, "_ovf"}, 64'(bus.o_overflow), 64'(exp_v));
   endtask

   task automatic retire();
      @(posedge clk);
      #1;
   endtask

   logic [31:0] bb_a [4];
   logic [31:0] bb_b [4];
   logic [31:0] bb_s [4];
   int          seen_valid;

   initial begin
      n_checks        = 0;
      n_errors        = 0;
      rst             = 1'b1;
      bus.i_valid     = 1'b0;
      bus.i_alu_op    = '0;
      bus.i_operand_a = '0;
      bus.i_operand_b = '0;
      bus.i_kill      = 1'b0;
      bus.i_ready     = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_valid", 64'(bus.o_valid), 64'h0);
      check_eq("rst_busy", 64'(bus.o_busy), 64'h0);
      check_eq("rst_result", 64'(bus.o_result), 64'h0);
      check_eq("rst_zero", 64'(bus.o_zero), 64'h1);
      check_eq("rst_ovf", 64'(bus.o_overflow), 64'h0);
      check_eq("rst_carry", 64'(bus.o_carry), 64'h0);
      check_eq("rst_ready", 64'(bus.o_ready), 64'h1);
      rst = 1'b0;
      retire();

      run_op("add_ovf", OP_ADD, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1); retire();
      run_op("add_cry", OP_ADD, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1); retire();
      run_op("sub_zero", OP_SUB, 32'h5, 32'h5, 32'h0, 1'b0, 1'b0, 1); retire();
      run_op("sub_brw", OP_SUB, 32'h0, 32'h1, 32'hFFFFFFFF, 1'b1, 1'b0, 1); retire();
      run_op("sub_ovf", OP_SUB, 32'h80000000, 32'h1, 32'h7FFFFFFF, 1'b0, 1'b1, 1); retire();
      run_op("sra", OP_SRA, 32'h80000000, 32'h21, 32'hC0000000, 1'b0, 1'b0, 1); retire();
      run_op("srl", OP_SRL, 32'h80000000, 32'h21, 32'h40000000, 1'b0, 1'b0, 1); retire();
      run_op("sll", OP_SLL, 32'h00000001, 32'h24, 32'h00000010, 1'b0, 1'b0, 1); retire();
      run_op("slt", OP_SLT, 32'hFFFFFFFF, 32'h1, 32'h1, 1'b0, 1'b0, 1); retire();
      run_op("sltu", OP_SLTU, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b0, 1'b0, 1); retire();
      run_op("xor", OP_XOR, 32'hF0F0FFFF, 32'h0F0F00FF, 32'hFFFFFF00, 1'b0, 1'b0, 1); retire();
      run_op("or", OP_OR, 32'hF0000000, 32'h0000000F, 32'hF000000F, 1'b0, 1'b0, 1); retire();
      run_op("and", OP_AND, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1); retire();
      run_op("bad_op", 5'b01001, 32'h12345678, 32'h1, 32'h0, 1'b0, 1'b0, 1); retire();

      run_op("mulh", OP_MULH, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0, 33);
      check_eq("mulh_busy", 64'(busy_cnt), 64'd32);
      retire();
      run_op("mulhu", OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 1'b0, 33); retire();
      run_op("mulhsu", OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 33); retire();
      run_op("mul", OP_MUL, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, 1'b0, 33); retire();

      run_op("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b0, 1); retire();
      run_op("rem_ovf", OP_REM, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0, 1); retire();
      run_op("divu_z", OP_DIVU, 32'h7, 32'h0, 32'hFFFFFFFF, 1'b0, 1'b0, 1); retire();
      run_op("rem_z", OP_REM, 32'h7, 32'h0, 32'h00000007, 1'b0, 1'b0, 1); retire();
      run_op("div", OP_DIV, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFD, 1'b0, 1'b0, 33); retire();
      run_op("divu", OP_DIVU, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0, 33); retire();
      run_op("remu", OP_REMU, 32'd100, 32'd7, 32'd2, 1'b0, 1'b0, 33); retire();

      // Consumer stalls: result must hold while i_ready is low
      bus.i_ready = 1'b0;
      run_op("rem", OP_REM, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 1'b0, 1'b0, 33);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check_eq("hold_valid", 64'(bus.o_valid), 64'h1);
         check_eq("hold_res", 64'(bus.o_result), 64'hFFFFFFFF);
      end
      bus.i_ready = 1'b1;
      retire();
      check_eq("hold_release", 64'(bus.o_valid), 64'h0);

      // Kill during the 10th DIVU iteration
      issue(OP_DIVU, 32'd1000, 32'd3);
      repeat (9) begin
         @(posedge clk);
         #1;
      end
      check_eq("kill_pre_busy", 64'(bus.o_busy), 64'h1);
      bus.i_kill = 1'b1;
      @(posedge clk);
      #1;
      bus.i_kill = 1'b0;
      check_eq("kill_valid", 64'(bus.o_valid), 64'h0);
      check_eq("kill_busy", 64'(bus.o_busy), 64'h0);
      check_eq("kill_ready", 64'(bus.o_ready), 64'h1);
      seen_valid = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (bus.o_valid) seen_valid++;
      end
      check_eq("kill_no_valid", 64'(seen_valid), 64'h0);

      // Kill in IDLE suppresses acceptance
      bus.i_kill = 1'b1;
      issue(OP_ADD, 32'h1, 32'h1);
      bus.i_kill = 1'b0;
      check_eq("kill_idle_valid", 64'(bus.o_valid), 64'h0);
      retire();
      check_eq("kill_idle_valid2", 64'(bus.o_valid), 64'h0);

      // Back-to-back ADDs, one result per cycle
      bb_a = '{32'h00000001, 32'hFFFFFFF0, 32'h12345678, 32'h00000007};
      bb_b = '{32'h00000002, 32'h00000010, 32'h11111111, 32'h00000008};
      bb_s = '{32'h00000003, 32'h00000000, 32'h23456789, 32'h0000000F};
      for (int k = 0; k < 4; k++) begin
         bus.i_valid     = 1'b1;
         bus.i_alu_op    = OP_ADD;
         bus.i_operand_a = bb_a[k];
         bus.i_operand_b = bb_b[k];
         @(posedge clk);
         #1;
         check_eq("b2b_valid", 64'(bus.o_valid), 64'h1);
         check_eq("b2b_res", 64'(bus.o_result), 64'(bb_s[k]));
      end
      bus.i_valid = 1'b0;
      retire();
      check_eq("b2b_end", 64'(bus.o_valid), 64'h0);

      // Reset in the middle of a multiply abandons it
      issue(OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF);
      repeat (5) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check_eq("rstb_busy", 64'(bus.o_busy), 64'h0);
      check_eq("rstb_valid", 64'(bus.o_valid), 64'h0);
      check_eq("rstb_result", 64'(bus.o_result), 64'h0);
      check_eq("rstb_zero", 64'(bus.o_zero), 64'h1);
      seen_valid = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (bus.o_valid) seen_valid++;
      end
      check_eq("rstb_no_valid", 64'(seen_valid), 64'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/rv16_alu_mc.md
RV16_ALU_MC -- requirements
Module: rv16_alu_mc

Interface
REQ-001 Parameter XLEN, default 32, operand/result width; SHALL be even and >= 8.
REQ-002 Derived localparam SHW = clog2(XLEN), shift-amount width; SHALL NOT be overridable.
REQ-003 i_clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 i_rst  input  1  reset, synchronous, active-high.
REQ-005 i_valid  input  1  request valid.
REQ-006 o_ready  output  1  block can accept a request this cycle.
REQ-007 i_alu_op  input  5  operation code (REQ-012).
REQ-008 i_operand_a / i_operand_b  input  XLEN each  operands.
REQ-009 i_kill  input  1  abort in-flight operation.
REQ-010 o_valid  output  1  result valid; i_ready  input  1  consumer accepts result.
REQ-011 o_result  output  XLEN; o_zero, o_overflow, o_carry, o_busy  output  1 each.

Function
REQ-012 Ops, bit4=0: ADD 00000, SUB 01000, SLL 00001, SLT 00010, SLTU 00011, XOR 00100, SRL 00101, SRA 01101, OR 00110, AND 00111. Bit4=1: MUL 10000, MULH 10001, MULHSU 10010, MULHU 10011, DIV 10100, DIVU 10101, REM 10110, REMU 10111. Any other code: result 0, flags 0, basic-op latency.
REQ-013 Accept = i_valid && o_ready at a rising edge; operands and op SHALL be captured at accept.
REQ-014 FSM states IDLE, BUSY, DONE. IDLE->DONE on accepting a basic or fast-path op; IDLE->BUSY on accepting any other M op; BUSY->DONE after exactly XLEN iteration cycles; DONE->IDLE on i_ready without new accept; DONE->DONE/BUSY on i_ready with a simultaneous accept.
REQ-015 o_ready = (state==IDLE) || (state==DONE && i_ready); o_valid = (state==DONE); o_busy = (state==BUSY).
REQ-016 Latency accept->o_valid: basic/fast-path ops 1 cycle; iterative M ops XLEN+1 cycles.
REQ-017 o_result and flags SHALL be registered, held stable while o_valid && !i_ready.
REQ-018 Shifts use operand_b[SHW-1:0] only; SRA is arithmetic, SRL logical.
REQ-019 ADD/SUB: carry = bit XLEN of the (XLEN+1)-bit unsigned sum/difference; overflow = signed two's-complement overflow. All other ops: carry = overflow = 0.
REQ-020 o_zero = (o_result == 0), registered with the result, for every op.
REQ-021 MUL returns low XLEN bits; MULH/MULHSU/MULHU return high XLEN bits of the 2*XLEN product with signed*signed, signed*unsigned, unsigned*unsigned interpretation.
REQ-022 Multiply SHALL be iterative shift-add, one bit per cycle; divide SHALL be iterative restoring, one quotient bit per cycle, with sign correction applied in the DONE transition.
REQ-023 Fast path, 1-cycle latency: divide-by-zero returns quotient all-ones (DIV/DIVU) and remainder = operand_a (REM/REMU); signed overflow (DIV of -2^(XLEN-1) by -1) returns quotient -2^(XLEN-1), remainder 0.
REQ-024 i_kill in BUSY or DONE SHALL return to IDLE next cycle, drop the result, and deassert o_valid; i_kill in IDLE SHALL suppress acceptance that cycle; i_kill has priority over accept and i_ready.

Reset
REQ-025 On i_rst: state IDLE, o_valid 0, o_busy 0, o_result 0, o_zero 1, o_overflow 0, o_carry 0, iteration counter 0.
REQ-026 i_rst during BUSY SHALL abandon the operation with no o_valid; i_rst has priority over i_kill and all handshakes.

Structure
REQ-027 Shared package rv16_alu_pkg SHALL hold the op encodings (REQ-012) and the FSM state type.
REQ-028 Iterative multiply/divide datapath SHALL be sub-module rv16_mdu_iter (start, op, operands, done, result); basic ops stay in the top module.

Verification
REQ-029 XLEN=32, ADD 0x7FFFFFFF+1 -> 1 cycle later o_result 0x80000000, overflow 1, carry 0, zero 0.
REQ-030 SUB 5-5 -> o_result 0, zero 1; SRA 0x80000000 by 0x21 -> 0xC0000000 (shamt 1).
REQ-031 MULH 0xFFFFFFFF*0xFFFFFFFF -> 0x00000000 after 33 cycles; MULHU same -> 0xFFFFFFFE; o_busy high for 32 cycles.
REQ-032 DIV 0x80000000/0xFFFFFFFF -> 0x80000000 in 1 cycle; DIVU 7/0 -> 0xFFFFFFFF; REM 7/0 -> 7.
REQ-033 DIV -7/2 -> -3 (0xFFFFFFFD), REM -7/2 -> -1; i_ready held low 5 cycles -> result and o_valid stable throughout.
REQ-034 i_kill at iteration 10 of DIVU -> IDLE next cycle, no o_valid; back-to-back ADDs with i_ready=1 -> one result per cycle.
